change_dispenser: RTL and testbench

Returns change from the vending datapath's credit total. Accepts a 7-bit cent amount, typically credit minus purchase price, and pays it out one coin at a time: quarters, dimes, then nickels. Each coin is a request/acknowledge handshake with the coin-ejector mechanism. When a coin tube is empty, the block falls back to smaller coins. At completion it reports how many of each coin it paid and any amount it could not pay.

---
 rtl/change_dispenser.sv | 138 +++++++++++++
 tb/tb_change_dispenser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays a cent balance out as quarters, dimes and nickels through a
// request/acknowledge handshake with the coin ejector, falling back when a tube is empty.
module change_dispenser #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         q_empty,
  input  logic         d_empty,
  input  logic         n_empty,
  input  logic         coin_ack,
  output logic         coin_q,
  output logic         coin_d,
  output logic         coin_n,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] change_left,
  output logic         short,
  output logic [2:0]   n_quarters,
  output logic [3:0]   n_dimes,
  output logic [4:0]   n_nickels
);

  localparam logic [W-1:0] QVal = W'(25);
  localparam logic [W-1:0] DVal = W'(10);
  localparam logic [W-1:0] NVal = W'(5);

  typedef enum logic [1:0] {StIdle, StSelect, StReq, StDone} state_e;
  typedef enum logic [1:0] {SelQ, SelD, SelN} sel_e;

  state_e       state_q, state_d;
  sel_e         sel_q, sel_d;
  logic [W-1:0] bal_q, bal_d;
  logic [W-1:0] left_q, left_d;
  logic         short_q, short_d;
  logic [2:0]   nq_q, nq_d;
  logic [3:0]   nd_q, nd_d;
  logic [4:0]   nn_q, nn_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= SelQ;
      bal_q   <= '0;
      left_q  <= '0;
      short_q <= 1'b0;
      nq_q    <= '0;
      nd_q    <= '0;
      nn_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bal_q   <= bal_d;
      left_q  <= left_d;
      short_q <= short_d;
      nq_q    <= nq_d;
      nd_q    <= nd_d;
      nn_q    <= nn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bal_d   = bal_q;
    left_d  = left_q;
    short_d = short_q;
    nq_d    = nq_q;
    nd_d    = nd_q;
    nn_d    = nn_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bal_d   = amount;
          nq_d    = '0;
          nd_d    = '0;
          nn_d    = '0;
          left_d  = '0;
          short_d = 1'b0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (bal_q >= QVal && !q_empty) begin
          sel_d   = SelQ;
          state_d = StReq;
        end else if (bal_q >= DVal && !d_empty) begin
          sel_d   = SelD;
          state_d = StReq;
        end else if (bal_q >= NVal && !n_empty) begin
          sel_d   = SelN;
          state_d = StReq;
        end else begin
          // Result is latched on entry to DONE so it is already valid while done is high.
          left_d  = bal_q;
          short_d = (bal_q >= NVal);
          state_d = StDone;
        end
      end
      StReq: begin
        if (coin_ack) begin
          unique case (sel_q)
            SelQ: begin
              bal_d = bal_q - QVal;
              nq_d  = nq_q + 3'd1;
            end
            SelD: begin
              bal_d = bal_q - DVal;
              nd_d  = nd_q + 4'd1;
            end
            SelN: begin
              bal_d = bal_q - NVal;
              nn_d  = nn_q + 5'd1;
            end
            default: ;
          endcase
          state_d = StSelect;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign coin_q      = (state_q == StReq) && (sel_q == SelQ);
  assign coin_d      = (state_q == StReq) && (sel_q == SelD);
  assign coin_n      = (state_q == StReq) && (sel_q == SelN);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign change_left = left_q;
  assign short       = short_q;
  assign n_quarters  = nq_q;
  assign n_dimes     = nd_q;
  assign n_nickels   = nn_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed cases plus random payouts checked against a greedy
// arithmetic model of the expected coin list, totals and done latency.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] amount;
  logic       q_empty, d_empty, n_empty;
  logic       coin_ack;
  logic       coin_q, coin_d, coin_n;
  logic       busy, done, short;
  logic [6:0] change_left;
  logic [2:0] n_quarters;
  logic [3:0] n_dimes;
  logic [4:0] n_nickels;

  int checks = 0;
  int errors = 0;

  change_dispenser #(.W(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .q_empty     (q_empty),
    .d_empty     (d_empty),
    .n_empty     (n_empty),
    .coin_ack    (coin_ack),
    .coin_q      (coin_q),
    .coin_d      (coin_d),
    .coin_n      (coin_n),
    .busy        (busy),
    .done        (done),
    .change_left (change_left),
    .short       (short),
    .n_quarters  (n_quarters),
    .n_dimes     (n_dimes),
    .n_nickels   (n_nickels)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coin codes as seen on {coin_q, coin_d, coin_n}.
  localparam logic [2:0] CodeQ = 3'b100;
  localparam logic [2:0] CodeD = 3'b010;
  localparam logic [2:0] CodeN = 3'b001;

  // idle_ack: coin_ack level driven while no coin is being requested (0 low, 1 high, 2 random).
  task automatic run_payout(input int amt, input bit qe, input bit de, input bit ne,
                            input int max_delay, input int idle_ack);
    logic [2:0] exp_coins[$];
    logic [2:0] coin, cur, exp_code;
    int nq, nd, nn, rem, k, extra, wait_left;
    bit in_req, acked, got_done, drive_idle;

    // Greedy payout, tube state fixed for the whole transaction.
    rem = amt;
    nq  = qe ? 0 : rem / 25;
    rem = rem - 25 * nq;
    nd  = de ? 0 : rem / 10;
    rem = rem - 10 * nd;
    nn  = ne ? 0 : rem / 5;
    rem = rem - 5 * nn;
    for (int i = 0; i < nq; i++) exp_coins.push_back(CodeQ);
    for (int i = 0; i < nd; i++) exp_coins.push_back(CodeD);
    for (int i = 0; i < nn; i++) exp_coins.push_back(CodeN);

    amount  = 7'(amt);
    q_empty = qe;
    d_empty = de;
    n_empty = ne;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    amount = 7'($urandom);
    check("start_busy", 32'(busy), 1);
    check("start_clr_q", 32'(n_quarters), 0);
    check("start_clr_left", 32'(change_left), 0);

    k = 0; extra = 0; wait_left = 0; cur = '0;
    in_req = 0; acked = 0; got_done = 0;
    while (!got_done && k < 600) begin
      if (done) begin
        got_done = 1;
      end else begin
        coin = {coin_q, coin_d, coin_n};
        drive_idle = 1;
        if (acked) begin
          check("coin_drop_after_ack", 32'(coin), 0);
          acked  = 0;
          in_req = 0;
        end else if (coin != 3'b000) begin
          if (!in_req) begin
            in_req   = 1;
            exp_code = (exp_coins.size() > 0) ? exp_coins.pop_front() : 3'b000;
            check("coin_seq", 32'(coin), 32'(exp_code));
            cur       = coin;
            wait_left = $urandom_range(max_delay, 0);
            extra     = extra + wait_left;
          end else begin
            check("coin_held", 32'(coin), 32'(cur));
          end
          drive_idle = 0;
          if (wait_left == 0) begin
            coin_ack = 1'b1;
            acked    = 1;
          end else begin
            coin_ack  = 1'b0;
            wait_left = wait_left - 1;
          end
        end
        if (drive_idle) begin
          coin_ack = (idle_ack == 2) ? 1'($urandom) : (idle_ack == 1);
        end
        check("busy_during", 32'(busy), 1);
        @(posedge clk);
        #1;
        k++;
      end
    end

    if (!got_done) begin
      check("done_timeout", 0, 1);
    end else begin
      // Done observed after edge E(2N+1+waits), so it is sampled at edge E(2N+2+waits).
      check("done_latency", 32'(k), 32'(2 * (nq + nd + nn) + 1 + extra));
      check("coins_left_unpaid", 32'(exp_coins.size()), 0);
      check("n_quarters", 32'(n_quarters), 32'(nq));
      check("n_dimes", 32'(n_dimes), 32'(nd));
      check("n_nickels", 32'(n_nickels), 32'(nn));
      check("change_left", 32'(change_left), 32'(rem));
      check("short", 32'(short), 32'(rem >= 5));
    end
    coin_ack = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("left_held", 32'(change_left), 32'(rem));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; amount = '0;
    q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0; coin_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_coins", 32'({coin_q, coin_d, coin_n}), 0);
    check("rst_short", 32'(short), 0);
    check("rst_left", 32'(change_left), 0);
    check("rst_counts", 32'({n_quarters, n_dimes, n_nickels}), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_payout(65, 0, 0, 0, 0, 1);   // Q Q D N, ack held high
    run_payout(40, 1, 0, 0, 0, 1);   // D D D D
    run_payout(17, 0, 0, 0, 0, 0);   // D N, residue 2
    run_payout(30, 0, 1, 1, 0, 0);   // one Q, short with 5 left
    run_payout(0, 0, 0, 0, 0, 2);    // no coins
    run_payout(127, 0, 0, 0, 2, 2);  // largest amount with stretched acks

    // Stalled dime: request held, start ignored, then async reset mid-payout.
    amount = 7'd10; q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("stall_coin_d", 32'(coin_d), 1);
    coin_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start  = (i == 1);
      amount = (i == 1) ? 7'd100 : 7'd10;
      @(posedge clk);
      #1;
      check("stall_coin_d_held", 32'(coin_d), 1);
      check("stall_coin_q_low", 32'(coin_q), 0);
      check("stall_busy", 32'(busy), 1);
    end
    start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_coins", 32'({coin_q, coin_d, coin_n}), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done_short", 32'({done, short}), 0);
    check("arst_counts", 32'({n_quarters, n_dimes, n_nickels}), 0);
    check("arst_left", 32'(change_left), 0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("arst_idle", 32'(busy), 0);

    for (int t = 0; t < 40; t++) begin
      run_payout($urandom_range(127, 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0), 3, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
